// File: rtl/ga_front_end.sv
`default_nettype none
// ============================================================================
//  Module   : ga_front_end
//  Purpose  : Front end of a genetic-algorithm path planner.
//             - Button pulser: one-cycle pulse per rising edge of a push
//               button. Optional 2-flop synchroniser when GA_BUTTON_SYNC_EN
//               is defined; without it, edge detection acts on the raw pin.
//             - Init engine: fills 50 x 150-bit paths from a 32-bit Galois
//               LFSR, one 32-bit word per cycle. The result is published at
//               completion only.
//             - Selection engine: scans 50 paths, ranks them by popcount and
//               publishes the 10 fittest (ties favour the lower path index).
//  Ports    : clk, rst (async, active high)
//             button          in   raw push-button level
//             button_p        out  one-cycle pulse per 0->1 button edge
//             prg_seed[31:0]  in   LFSR seed (0 is replaced by 32'hACE12025)
//             init_start      in   start population initialisation
//             init_population out  50 paths x 150 bits, path i at [150i+:150]
//             init_done       out  one-cycle completion pulse
//             init_busy       out  init engine running
//             sel_start       in   start selection
//             pop[7499:0]     in   population to select from
//             sel_population  out  10 selected paths x 150 bits, slot 0 best
//             sel_done        out  one-cycle completion pulse
//             sel_busy        out  selection engine running
//  Config   : `define GA_BUTTON_SYNC_EN to add the button synchroniser.
//  Revision : 1.0 - initial release
// ============================================================================
module ga_front_end (
  input  logic          clk,
  input  logic          rst,
  input  logic          button,
  output logic          button_p,
  input  logic [31:0]   prg_seed,
  input  logic          init_start,
  output logic [7499:0] init_population,
  output logic          init_done,
  input  logic          sel_start,
  input  logic [7499:0] pop,
  output logic [1499:0] sel_population,
  output logic          sel_done,
  output logic          init_busy,
  output logic          sel_busy
);

  localparam int          PATH_W    = 150;
  localparam int          POP_W     = 7500;
  localparam int          N_SEL     = 10;
  localparam int          N_FULL_W  = 234;           // words stored in full
  localparam logic [7:0]  LAST_WORD = 8'd234;        // truncated to 12 bits
  localparam logic [7:0]  INIT_END  = 8'd235;
  localparam logic [5:0]  SEL_END   = 6'd50;
  localparam logic [31:0] SEED_ALT  = 32'hACE12025;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // --------------------------------------------------------------------------
  // Button pulser
  // --------------------------------------------------------------------------
  logic w_level;
  logic r_level_d;

`ifdef GA_BUTTON_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = r_sync2;
`else
  assign w_level = button;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= 1'b0;
      button_p  <= 1'b0;
    end else begin
      r_level_d <= w_level;
      button_p  <= w_level & ~r_level_d;
    end
  end

  // --------------------------------------------------------------------------
  // Init engine
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    INIT_IDLE = 1'b0,
    INIT_RUN  = 1'b1
  } init_state_t;

  init_state_t r_init_state;
  init_state_t w_init_next;
  logic        w_init_load;
  logic        w_init_step;
  logic        w_init_finish;

  logic [31:0]                r_lfsr;
  logic [31:0]                w_lfsr_next;
  logic [7:0]                 r_word_cnt;
  logic [N_FULL_W-1:0][31:0]  r_words;
  logic [11:0]                r_last;

  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
  assign init_busy   = (r_init_state == INIT_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_state <= INIT_IDLE;
    end else begin
      r_init_state <= w_init_next;
    end
  end

  always_comb begin
    w_init_next   = r_init_state;
    w_init_load   = 1'b0;
    w_init_step   = 1'b0;
    w_init_finish = 1'b0;
    case (r_init_state)
      INIT_IDLE: begin
        if (init_start) begin
          w_init_load = 1'b1;
          w_init_next = INIT_RUN;
        end
      end
      INIT_RUN: begin
        if (r_word_cnt == INIT_END) begin
          w_init_finish = 1'b1;
          w_init_next   = INIT_IDLE;
        end else begin
          w_init_step = 1'b1;
        end
      end
      default: w_init_next = INIT_IDLE;
    endcase
  end

  // Words are built in a private buffer; the visible population only changes
  // at completion so a consumer never sees a half-filled population.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr          <= '0;
      r_word_cnt      <= '0;
      r_words         <= '0;
      r_last          <= '0;
      init_population <= '0;
      init_done       <= 1'b0;
    end else begin
      init_done <= w_init_finish;
      if (w_init_load) begin
        // An all-zero seed would lock the LFSR at zero forever.
        r_lfsr     <= (prg_seed == 32'h0) ? SEED_ALT : prg_seed;
        r_word_cnt <= '0;
      end
      if (w_init_step) begin
        r_lfsr     <= w_lfsr_next;
        r_word_cnt <= r_word_cnt + 8'd1;
        if (r_word_cnt == LAST_WORD) begin
          r_last <= w_lfsr_next[11:0];
        end else begin
          r_words[r_word_cnt] <= w_lfsr_next;
        end
      end
      if (w_init_finish) begin
        init_population <= {r_last, r_words};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Selection engine
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    SEL_IDLE = 1'b0,
    SEL_RUN  = 1'b1
  } sel_state_t;

  sel_state_t r_sel_state;
  sel_state_t w_sel_next;
  logic       w_sel_load;
  logic       w_sel_step;
  logic       w_sel_finish;

  logic [POP_W-1:0]              r_snap;
  logic [5:0]                    r_sel_cnt;
  logic [N_SEL-1:0][PATH_W-1:0]  r_list_path;
  logic [N_SEL-1:0][7:0]         r_list_fit;
  logic [N_SEL-1:0]              r_list_vld;

  logic [PATH_W-1:0]             w_cur_path;
  logic [7:0]                    w_cur_fit;
  logic [N_SEL-1:0]              w_keep;
  logic [N_SEL-1:0]              w_prev_keep;
  logic [N_SEL-1:0][PATH_W-1:0]  w_shift_path;
  logic [N_SEL-1:0][7:0]         w_shift_fit;
  logic [N_SEL-1:0]              w_shift_vld;

  function automatic logic [7:0] popcount150(input logic [PATH_W-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int b = 0; b < PATH_W; b++) begin
      c = c + {7'd0, v[b]};
    end
    return c;
  endfunction

  assign sel_busy = (r_sel_state == SEL_RUN);

  // The snapshot shifts down one path per cycle, so the path under test is
  // always the bottom 150 bits.
  assign w_cur_path = r_snap[PATH_W-1:0];
  assign w_cur_fit  = popcount150(w_cur_path);

  // A slot keeps its entry when that entry is at least as fit as the
  // candidate; equal fitness means the earlier (lower-index) path stays ahead.
  always_comb begin
    w_keep = '0;
    for (int j = 0; j < N_SEL; j++) begin
      w_keep[j] = r_list_vld[j] && (r_list_fit[j] >= w_cur_fit);
    end
  end

  // Slot j receives the candidate when its predecessor is kept (or j == 0);
  // otherwise it inherits the entry from slot j-1.
  assign w_prev_keep  = {w_keep[N_SEL-2:0], 1'b1};
  assign w_shift_path = {r_list_path[N_SEL-2:0], {PATH_W{1'b0}}};
  assign w_shift_fit  = {r_list_fit[N_SEL-2:0], 8'd0};
  assign w_shift_vld  = {r_list_vld[N_SEL-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_state <= SEL_IDLE;
    end else begin
      r_sel_state <= w_sel_next;
    end
  end

  always_comb begin
    w_sel_next   = r_sel_state;
    w_sel_load   = 1'b0;
    w_sel_step   = 1'b0;
    w_sel_finish = 1'b0;
    case (r_sel_state)
      SEL_IDLE: begin
        if (sel_start) begin
          w_sel_load = 1'b1;
          w_sel_next = SEL_RUN;
        end
      end
      SEL_RUN: begin
        if (r_sel_cnt == SEL_END) begin
          w_sel_finish = 1'b1;
          w_sel_next   = SEL_IDLE;
        end else begin
          w_sel_step = 1'b1;
        end
      end
      default: w_sel_next = SEL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap         <= '0;
      r_sel_cnt      <= '0;
      r_list_path    <= '0;
      r_list_fit     <= '0;
      r_list_vld     <= '0;
      sel_population <= '0;
      sel_done       <= 1'b0;
    end else begin
      sel_done <= w_sel_finish;
      if (w_sel_load) begin
        r_snap     <= pop;
        r_sel_cnt  <= '0;
        r_list_vld <= '0;
      end
      if (w_sel_step) begin
        r_snap    <= {{PATH_W{1'b0}}, r_snap[POP_W-1:PATH_W]};
        r_sel_cnt <= r_sel_cnt + 6'd1;
        for (int j = 0; j < N_SEL; j++) begin
          if (!w_keep[j]) begin
            if (w_prev_keep[j]) begin
              r_list_path[j] <= w_cur_path;
              r_list_fit[j]  <= w_cur_fit;
              r_list_vld[j]  <= 1'b1;
            end else begin
              r_list_path[j] <= w_shift_path[j];
              r_list_fit[j]  <= w_shift_fit[j];
              r_list_vld[j]  <= w_shift_vld[j];
            end
          end
        end
      end
      if (w_sel_finish) begin
        sel_population <= r_list_path;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ga_front_end.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ga_front_end
//  Purpose  : Self-checking bench for ga_front_end: table-driven pulser
//             vectors plus directed multi-cycle sequences for the init and
//             selection engines, concurrency, restart-ignore and reset abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ga_front_end;

  logic          clk = 1'b0;
  logic          rst;
  logic          button;
  logic          button_p;
  logic [31:0]   prg_seed;
  logic          init_start;
  logic [7499:0] init_population;
  logic          init_done;
  logic          sel_start;
  logic [7499:0] pop;
  logic [1499:0] sel_population;
  logic          sel_done;
  logic          init_busy;
  logic          sel_busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef GA_BUTTON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  ga_front_end dut (
    .clk             (clk),
    .rst             (rst),
    .button          (button),
    .button_p        (button_p),
    .prg_seed        (prg_seed),
    .init_start      (init_start),
    .init_population (init_population),
    .init_done       (init_done),
    .sel_start       (sel_start),
    .pop             (pop),
    .sel_population  (sel_population),
    .sel_done        (sel_done),
    .init_busy       (init_busy),
    .sel_busy        (sel_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic btn;
    logic exp_p;
  } pvec_t;

  pvec_t ptab [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [7499:0] act, input logic [7499:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int b = 7499; b >= 0; b--) begin
      if (act[b] !== exp[b]) bad = b;
    end
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: first difference at bit %0d, actual %b required %b",
               nm, bad, act[bad], exp[bad]);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [31:0] state_after(input logic [31:0] seed, input int n);
    logic [31:0] s;
    s = (seed == 32'h0) ? 32'hACE12025 : seed;
    for (int k = 0; k < n; k++) s = lfsr_step(s);
    return s;
  endfunction

  function automatic logic [7499:0] init_model(input logic [31:0] seed);
    logic [7499:0] r;
    logic [31:0]   s;
    r = '0;
    s = (seed == 32'h0) ? 32'hACE12025 : seed;
    for (int k = 0; k < 235; k++) begin
      s = lfsr_step(s);
      if (k < 234) r[k*32 +: 32] = s;
      else         r[7499:7488]  = s[11:0];
    end
    return r;
  endfunction

  // Runs one init operation, tries a restart mid-run and changes the seed
  // after the start edge; both must have no effect.
  task automatic run_init(input logic [31:0] seed, input logic [7499:0] prev);
    int lat;
    lat        = -1;
    prg_seed   = seed;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    prg_seed   = 32'h5A5A1234;
    check("init_busy after start", {31'd0, init_busy}, 32'd1);
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (n == 50) init_start = 1'b1;
      if (n == 51) init_start = 1'b0;
      if (n == 100) check_vec("init_population hold", init_population, prev);
      if (init_done) begin
        lat = n;
        break;
      end
    end
    check("init_done latency", lat, 32'd236);
    check("init_busy at done", {31'd0, init_busy}, 32'd0);
    tick();
    check("init_done width", {31'd0, init_done}, 32'd0);
  endtask

  task automatic run_sel(input logic [7499:0] p, input logic [1499:0] prev);
    int lat;
    lat       = -1;
    pop       = p;
    sel_start = 1'b1;
    tick();
    sel_start = 1'b0;
    pop       = ~p;
    check("sel_busy after start", {31'd0, sel_busy}, 32'd1);
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (n == 10) sel_start = 1'b1;
      if (n == 11) sel_start = 1'b0;
      if (n == 25) check_vec("sel_population hold", {6000'd0, sel_population}, {6000'd0, prev});
      if (sel_done) begin
        lat = n;
        break;
      end
    end
    check("sel_done latency", lat, 32'd51);
    check("sel_busy at done", {31'd0, sel_busy}, 32'd0);
    tick();
    check("sel_done width", {31'd0, sel_done}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7499:0] pop1, pop2, res0, exp_v;
    logic [1499:0] sel1, exp_s;
    logic [31:0]   tmp;
    int            cnt, first, idx, dn;
    logic          exp_p;

    // Pulser vectors; exp_p is the unsynchronised (1-edge) response.
    ptab[0]  = '{1'b0, 1'b0};  ptab[1]  = '{1'b1, 1'b1};
    ptab[2]  = '{1'b1, 1'b0};  ptab[3]  = '{1'b1, 1'b0};
    ptab[4]  = '{1'b0, 1'b0};  ptab[5]  = '{1'b1, 1'b1};
    ptab[6]  = '{1'b0, 1'b0};  ptab[7]  = '{1'b0, 1'b0};
    ptab[8]  = '{1'b1, 1'b1};  ptab[9]  = '{1'b1, 1'b0};
    ptab[10] = '{1'b1, 1'b0};  ptab[11] = '{1'b1, 1'b0};
    ptab[12] = '{1'b0, 1'b0};  ptab[13] = '{1'b0, 1'b0};
    ptab[14] = '{1'b1, 1'b1};  ptab[15] = '{1'b0, 1'b0};

    rst        = 1'b1;
    button     = 1'b0;
    prg_seed   = 32'h0;
    init_start = 1'b0;
    sel_start  = 1'b0;
    pop        = '0;
    repeat (3) tick();
    check("reset button_p", {31'd0, button_p}, 32'd0);
    check("reset init_done", {31'd0, init_done}, 32'd0);
    check("reset sel_done", {31'd0, sel_done}, 32'd0);
    check("reset init_busy", {31'd0, init_busy}, 32'd0);
    check("reset sel_busy", {31'd0, sel_busy}, 32'd0);
    check_vec("reset init_population", init_population, '0);
    check_vec("reset sel_population", {6000'd0, sel_population}, '0);
    rst = 1'b0;
    repeat (3) tick();

    // Pulser table
    for (int i = 0; i < 16; i++) begin
      button = ptab[i].btn;
      tick();
      idx   = i - (LAT - 1);
      exp_p = (idx >= 0) ? ptab[idx].exp_p : 1'b0;
      check($sformatf("button_p vec %0d", i), {31'd0, button_p}, {31'd0, exp_p});
    end

    // Held button: exactly one pulse, after the expected edge
    button = 1'b0;
    repeat (5) tick();
    button = 1'b1;
    cnt    = 0;
    first  = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (button_p) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    button = 1'b0;
    check("held button pulse count", cnt, 32'd1);
    check("held button pulse edge", first, LAT - 1);

    // Init with seed 1
    run_init(32'd1, '0);
    check("init word0 seed1", init_population[31:0], 32'h80200003);
    tmp = state_after(32'd1, 235);
    check("init top12 seed1", {20'd0, init_population[7499:7488]}, {20'd0, tmp[11:0]});
    exp_v = init_model(32'd1);
    check_vec("init population seed1", init_population, exp_v);

    // Seed 0 must behave as 32'hACE12025
    run_init(32'd0, exp_v);
    res0 = init_population;
    check_vec("init population seed0", res0, init_model(32'hACE12025));
    run_init(32'hACE12025, res0);
    check_vec("seed0 equals ACE12025", init_population, res0);

    // Selection: path i has i low ones
    pop1 = '0;
    for (int i = 0; i < 50; i++)
      for (int b = 0; b < i; b++) pop1[i*150 + b] = 1'b1;
    run_sel(pop1, '0);
    sel1  = sel_population;
    exp_s = '0;
    for (int j = 0; j < 10; j++) exp_s[j*150 +: 150] = pop1[(49-j)*150 +: 150];
    check_vec("sel ranked paths", {6000'd0, sel1}, {6000'd0, exp_s});

    // All paths equally fit (one distinct bit each), init running alongside
    pop2 = '0;
    for (int i = 0; i < 50; i++) pop2[i*150 + i] = 1'b1;
    fork
      run_sel(pop2, sel1);
      run_init(32'd1, res0);
    join
    exp_s = '0;
    for (int j = 0; j < 10; j++) exp_s[j*150 +: 150] = pop2[j*150 +: 150];
    check_vec("sel ties lower index", {6000'd0, sel_population}, {6000'd0, exp_s});
    check_vec("init concurrent seed1", init_population, exp_v);

    // Reset 100 cycles into an init run
    prg_seed   = 32'd1;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (99) tick();
    #2;
    rst = 1'b1;
    #1;
    check("abort init_busy", {31'd0, init_busy}, 32'd0);
    check("abort init_done", {31'd0, init_done}, 32'd0);
    check_vec("abort init_population", init_population, '0);
    check_vec("abort sel_population", {6000'd0, sel_population}, '0);
    tick();
    rst = 1'b0;
    dn  = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (init_done) dn++;
    end
    check("no done after abort", dn, 32'd0);
    run_init(32'd1, '0);
    check_vec("init after abort", init_population, exp_v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ga_front_end.md
GA_FRONT_END -- requirements
Module: ga_front_end

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  async active-high reset
- button  in  1  raw push-button level
- button_p  out  1  one-cycle pulse per button rising edge
- prg_seed  in  32  free-running seed value
- init_start  in  1  start population initialisation
- init_population  out  7500  50 paths x 150 bits
- init_done  out  1  one-cycle completion pulse
- sel_start  in  1  start selection
- pop  in  7500  population to select from
- sel_population  out  1500  10 selected paths x 150 bits
- sel_done  out  1  one-cycle completion pulse
- init_busy, sel_busy  out  1 each  engine running
REQ-003 Path i SHALL occupy bits [150i+149:150i] in pop, init_population and sel_population.

Function
REQ-004 Pulser: button_p SHALL be registered and equal sync_level AND NOT previous sync_level, so it is high exactly one cycle per 0->1 transition; a held button gives no further pulses.
REQ-005 Init engine: init_start sampled high while idle SHALL load a 32-bit Galois LFSR with prg_seed; if prg_seed is 0, it loads 32'hACE12025 instead.
REQ-006 LFSR step: state = (state >> 1) XOR (state[0] ? 32'h80200003 : 0).
REQ-007 Word k (k = 0..234) SHALL equal the LFSR state after k+1 steps, written to init_population[32k+31:32k]; word 234 is truncated to its low 12 bits.
REQ-008 One word per cycle: words written on edges 1..235 after the start edge; init_done high for the single cycle after edge 236; init_busy high from edge 1 through edge 236.
REQ-009 Init engine: init_population SHALL hold its last value until the next completion.
REQ-010 Selection: sel_start sampled high while idle SHALL snapshot pop; fitness(path) = popcount of its 150 bits (8-bit unsigned).
REQ-011 Selection SHALL scan paths 0..49, one per cycle on edges 1..50, inserting into a sorted 10-entry list (slot 0 = highest fitness); ties keep the lower path index in the better slot.
REQ-012 Selection: sel_population updates on edge 51 only; sel_done high for that one cycle; sel_busy high edges 1..51; sel_population holds otherwise.
REQ-013 A start asserted while the same engine is busy SHALL be ignored; the two engines are independent and may run concurrently.
REQ-014 Changes on pop or prg_seed after the start edge SHALL NOT affect a running operation.

Reset
REQ-015 rst SHALL asynchronously clear button_p, init_done, sel_done, both busy flags, init_population, sel_population, the LFSR and all synchroniser/edge flops to 0; both engines return to idle.
REQ-016 rst mid-operation SHALL abort the operation with no done pulse; the first start after rst release behaves as from power-up.

Configuration
REQ-017 Macro GA_BUTTON_SYNC_EN defined: button SHALL pass a 2-flop synchroniser before edge detection, so button_p rises after the 3rd edge following button high.
REQ-018 Macro GA_BUTTON_SYNC_EN undefined: edge detection SHALL act directly on button, so button_p rises after the 1st edge.

Verification
REQ-019 With GA_BUTTON_SYNC_EN undefined, button held high for 20 cycles -> exactly one button_p pulse, 1 cycle wide, after the first edge; with it defined, the pulse comes after the third edge.
REQ-020 init_start with prg_seed=1 -> init_done exactly 236 cycles after the start edge; word 0 = 32'h80200003; bits [7499:7488] = the low 12 bits of the state after 235 steps.
REQ-021 init_start with prg_seed=0 -> same output as prg_seed=32'hACE12025.
REQ-022 sel_start with path i = i ones (low bits set), i = 0..49 -> sel_done after 51 cycles; slot 0 = path 49 ... slot 9 = path 40.
REQ-023 sel_start with all paths equal -> slots 0..9 = paths 0..9; a second sel_start at cycle 10 is ignored.
REQ-024 rst asserted at cycle 100 of init -> all outputs 0 immediately, no init_done; a new init_start then completes normally.
